// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
//   state_t : arbiter FSM encoding (IDLE / CPU_ACC / ACC_ACC)
//   owner_t : which requester held the memory most recently
//   SZ_*    : size codes on the *_size and mem_byte_size lines
//   rr_pick : IDLE-state pick between the two requesters
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_ACC = 2'd1,
        ACC_ACC = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_ACC = 1'b1
    } owner_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // On a tie the requester that did not own the memory last goes next,
    // so back-to-back contention alternates strictly.
    function automatic state_t rr_pick(input logic   cpu_req,
                                       input logic   acc_req,
                                       input owner_t last_owner);
        state_t pick;
        if (cpu_req && acc_req)
            pick = (last_owner == OWN_ACC) ? CPU_ACC : ACC_ACC;
        else if (cpu_req)
            pick = CPU_ACC;
        else if (acc_req)
            pick = ACC_ACC;
        else
            pick = IDLE;
        return pick;
    endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data_mem between the CPU load/store
// unit and the ASCON data mover. One access per arbitration; the accelerator
// may lock the memory for up to LOCK_MAX consecutive beats.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no owner; mem_* lines quiet; pick the next owner
// CPU_ACC | CPU owns the memory for this cycle
// ACC_ACC | accelerator owns the memory; may repeat while acc_lock set
//
// Ports:
//   clock, reset_n                  system clock, async active-low reset
//   cpu_* / acc_*  (req, we, addr, wdata, size, sext)  requester payloads
//   acc_lock                        keep the grant for the next acc beat
//   cpu_gnt / acc_gnt               access performed this cycle
//   cpu_rvalid/rdata, acc_rvalid/rdata  registered load return
//   mem_*                           data_mem address/control/data
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [1:0]        cpu_size,
    input  logic              cpu_sext,
    input  logic              acc_req,
    input  logic              acc_we,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic [DATA_W-1:0] acc_wdata,
    input  logic [1:0]        acc_size,
    input  logic              acc_sext,
    input  logic              acc_lock,
    output logic              cpu_gnt,
    output logic              acc_gnt,
    output logic              cpu_rvalid,
    output logic              acc_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [DATA_W-1:0] acc_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_memwrite,
    output logic              mem_memread,
    output logic [1:0]        mem_byte_size,
    output logic              mem_sign_ext,
    input  logic [DATA_W-1:0] mem_read_data
);

    // Last lock_cnt value that still allows another locked beat.
    localparam logic [7:0] LOCK_LAST = 8'(LOCK_MAX - 1);

    state_t     state_q, state_d;
    owner_t     last_owner_q;
    logic [7:0] lock_cnt_q, lock_cnt_d;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_owner_q <= OWN_ACC;
            lock_cnt_q   <= 8'd0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            if (state_q == CPU_ACC)
                last_owner_q <= OWN_CPU;
            else if (state_q == ACC_ACC)
                last_owner_q <= OWN_ACC;
        end
    end

    // Next-state logic. A locked beat counts even if acc_req is low, which
    // bounds how long the CPU can be held off.
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        case (state_q)
            IDLE:    state_d = rr_pick(cpu_req, acc_req, last_owner_q);
            CPU_ACC: state_d = IDLE;
            ACC_ACC: begin
                if (acc_lock && (lock_cnt_q < LOCK_LAST)) begin
                    state_d    = ACC_ACC;
                    lock_cnt_d = lock_cnt_q + 8'd1;
                end else begin
                    state_d    = IDLE;
                    lock_cnt_d = 8'd0;
                end
            end
            default: begin
                state_d    = IDLE;
                lock_cnt_d = 8'd0;
            end
        endcase
    end

    // Output logic: the owner's payload reaches data_mem only while its
    // request is still up, so a dropped request performs no access.
    always_comb begin
        cpu_gnt        = 1'b0;
        acc_gnt        = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        mem_memwrite   = 1'b0;
        mem_memread    = 1'b0;
        mem_byte_size  = 2'b00;
        mem_sign_ext   = 1'b0;
        case (state_q)
            CPU_ACC: begin
                if (cpu_req) begin
                    cpu_gnt        = 1'b1;
                    mem_address    = cpu_addr;
                    mem_write_data = cpu_wdata;
                    mem_memwrite   = cpu_we;
                    mem_memread    = ~cpu_we;
                    mem_byte_size  = cpu_size;
                    mem_sign_ext   = cpu_sext;
                end
            end
            ACC_ACC: begin
                if (acc_req) begin
                    acc_gnt        = 1'b1;
                    mem_address    = acc_addr;
                    mem_write_data = acc_wdata;
                    mem_memwrite   = acc_we;
                    mem_memread    = ~acc_we;
                    mem_byte_size  = acc_size;
                    mem_sign_ext   = acc_sext;
                end
            end
            default: ;
        endcase
    end

    // Load return: capture on the edge that ends a granted load.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cpu_rvalid <= 1'b0;
            acc_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            acc_rdata  <= '0;
        end else begin
            cpu_rvalid <= cpu_gnt & ~cpu_we;
            acc_rvalid <= acc_gnt & ~acc_we;
            if (cpu_gnt && !cpu_we)
                cpu_rdata <= mem_read_data;
            if (acc_gnt && !acc_we)
                acc_rdata <= mem_read_data;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small byte-addressed data_mem model
// (little-endian, 256 bytes, indexed by address[7:0]).
module tb_dmem_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        cpu_req, cpu_we, cpu_sext, acc_req, acc_we, acc_sext, acc_lock;
    logic [31:0] cpu_addr, cpu_wdata, acc_addr, acc_wdata;
    logic [1:0]  cpu_size, acc_size;
    logic        cpu_gnt, acc_gnt, cpu_rvalid, acc_rvalid;
    logic [31:0] cpu_rdata, acc_rdata;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_memwrite, mem_memread, mem_sign_ext;
    logic [1:0]  mem_byte_size;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .LOCK_MAX(8)) dut (
        .clock(clock), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_size(cpu_size), .cpu_sext(cpu_sext),
        .acc_req(acc_req), .acc_we(acc_we), .acc_addr(acc_addr),
        .acc_wdata(acc_wdata), .acc_size(acc_size), .acc_sext(acc_sext),
        .acc_lock(acc_lock),
        .cpu_gnt(cpu_gnt), .acc_gnt(acc_gnt),
        .cpu_rvalid(cpu_rvalid), .acc_rvalid(acc_rvalid),
        .cpu_rdata(cpu_rdata), .acc_rdata(acc_rdata),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
        .mem_byte_size(mem_byte_size), .mem_sign_ext(mem_sign_ext),
        .mem_read_data(mem_read_data)
    );

    // data_mem model
    logic [7:0] mem [0:255];
    logic [7:0] ma0, ma1, ma2, ma3;
    assign ma0 = mem_address[7:0];
    assign ma1 = ma0 + 8'd1;
    assign ma2 = ma0 + 8'd2;
    assign ma3 = ma0 + 8'd3;

    always_comb begin
        mem_read_data = '0;
        case (mem_byte_size)
            2'b00:   mem_read_data = mem_sign_ext ? {{24{mem[ma0][7]}}, mem[ma0]}
                                                  : {24'd0, mem[ma0]};
            2'b01:   mem_read_data = mem_sign_ext ? {{16{mem[ma1][7]}}, mem[ma1], mem[ma0]}
                                                  : {16'd0, mem[ma1], mem[ma0]};
            default: mem_read_data = {mem[ma3], mem[ma2], mem[ma1], mem[ma0]};
        endcase
    end

    always @(posedge clock) begin
        if (mem_memwrite) begin
            mem[ma0] <= mem_write_data[7:0];
            if (mem_byte_size != 2'b00) mem[ma1] <= mem_write_data[15:8];
            if (mem_byte_size == 2'b10) begin
                mem[ma2] <= mem_write_data[23:16];
                mem[ma3] <= mem_write_data[31:24];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_size = 2'b10; cpu_sext = 0;
        acc_req = 0; acc_we = 0; acc_addr = 0; acc_wdata = 0; acc_size = 2'b10; acc_sext = 0;
        acc_lock = 0;
    endtask

    // Called at posedge+1 with the arbiter in IDLE; returns at posedge+1 with IDLE.
    task automatic cpu_op(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] size,
                          input logic sext, input logic [31:0] exp_rdata);
        cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        cpu_size = size; cpu_sext = sext;
        @(negedge clock);
        chk({tag, "_gnt_n"}, {31'd0, cpu_gnt}, 32'd0);
        next_cycle();
        @(negedge clock);
        chk({tag, "_gnt_n1"}, {31'd0, cpu_gnt}, 32'd1);
        chk({tag, "_wr_en"}, {31'd0, mem_memwrite}, {31'd0, we});
        chk({tag, "_rd_en"}, {31'd0, mem_memread}, {31'd0, ~we});
        chk({tag, "_addr"}, mem_address, addr);
        next_cycle();
        cpu_req = 0;
        @(negedge clock);
        chk({tag, "_rvalid"}, {31'd0, cpu_rvalid}, {31'd0, ~we});
        if (!we) chk({tag, "_rdata"}, cpu_rdata, exp_rdata);
        next_cycle();
    endtask

    task automatic apply_reset();
        reset_n = 0;
        next_cycle();
        reset_n = 1;
    endtask

    logic [11:0] cg, ag, cv, av;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        clear_inputs();
        reset_n = 0;
        #2;
        chk("rst_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
        chk("rst_acc_gnt", {31'd0, acc_gnt}, 32'd0);
        chk("rst_rvalid", {30'd0, cpu_rvalid, acc_rvalid}, 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_acc_rdata", acc_rdata, 32'd0);
        chk("rst_mem_ctl", {27'd0, mem_memwrite, mem_memread, mem_byte_size, mem_sign_ext}, 32'd0);
        chk("rst_mem_addr", mem_address, 32'd0);
        next_cycle();
        reset_n = 1;
        next_cycle();

        // store word then load it back
        cpu_op("sw", 1, 32'h1000_0010, 32'hDEAD_BEEF, 2'b10, 0, 32'd0);
        chk("sw_mem", {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}, 32'hDEAD_BEEF);
        cpu_op("lw", 0, 32'h1000_0010, 32'd0, 2'b10, 0, 32'hDEAD_BEEF);

        // byte 0x80: signed and unsigned load, plus a signed halfword
        cpu_op("sb", 1, 32'h1000_0021, 32'h0000_0080, 2'b00, 0, 32'd0);
        cpu_op("lb", 0, 32'h1000_0021, 32'd0, 2'b00, 1, 32'hFFFF_FF80);
        cpu_op("lbu", 0, 32'h1000_0021, 32'd0, 2'b00, 0, 32'h0000_0080);
        cpu_op("lh", 0, 32'h1000_0012, 32'd0, 2'b01, 1, 32'hFFFF_DEAD);

        // both requesters held from reset: CPU, ACC, CPU, ACC
        clear_inputs();
        reset_n = 0;
        cpu_req = 1; cpu_addr = 32'h1000_0010;
        acc_req = 1; acc_addr = 32'h1000_0020;
        next_cycle();
        reset_n = 1;
        cg = '0; ag = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            cg[i] = cpu_gnt; ag[i] = acc_gnt;
            next_cycle();
        end
        chk("rr_cpu_gnt", {24'd0, cg[7:0]}, 32'h0000_0022);
        chk("rr_acc_gnt", {24'd0, ag[7:0]}, 32'h0000_0088);

        // locked accelerator burst with the CPU waiting behind it
        clear_inputs();
        apply_reset();
        acc_req = 1; acc_lock = 1; acc_addr = 32'h1000_0010;
        cpu_addr = 32'h1000_0010;
        cg = '0; ag = '0; cv = '0; av = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            cg[i] = cpu_gnt; ag[i] = acc_gnt; cv[i] = cpu_rvalid; av[i] = acc_rvalid;
            next_cycle();
            cpu_req = 1;
        end
        chk("lock_acc_gnt", {20'd0, ag}, 32'h0000_01FE);
        chk("lock_cpu_gnt", {20'd0, cg}, 32'h0000_0400);
        chk("lock_acc_rvalid", {20'd0, av}, 32'h0000_03FC);
        chk("lock_cpu_rvalid", {20'd0, cv}, 32'h0000_0800);
        chk("lock_acc_rdata", acc_rdata, 32'hDEAD_BEEF);

        // async reset in the middle of a CPU store cycle
        clear_inputs();
        apply_reset();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h1000_0030; cpu_wdata = 32'h1234_5678;
        next_cycle();
        chk("ar_wr_before", {31'd0, mem_memwrite}, 32'd1);
        #2;
        reset_n = 0;
        #1;
        chk("ar_wr_drop", {31'd0, mem_memwrite}, 32'd0);
        chk("ar_gnt", {31'd0, cpu_gnt}, 32'd0);
        chk("ar_addr", mem_address, 32'd0);
        cpu_req = 0;
        next_cycle();
        chk("ar_mem", {mem[8'h33], mem[8'h32], mem[8'h31], mem[8'h30]}, 32'd0);
        chk("ar_outs", {28'd0, cpu_rvalid, acc_rvalid, cpu_gnt, acc_gnt}, 32'd0);
        chk("ar_rdata", cpu_rdata | acc_rdata, 32'd0);
        reset_n = 1;
        next_cycle();

        // request dropped in its own ACC cycle
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h1000_0010;
        next_cycle();
        cpu_req = 0;
        @(negedge clock);
        chk("drop_gnt", {31'd0, cpu_gnt}, 32'd0);
        chk("drop_rd_en", {31'd0, mem_memread}, 32'd0);
        chk("drop_addr", mem_address, 32'd0);
        next_cycle();
        acc_req = 1; acc_we = 0; acc_addr = 32'h1000_0010; acc_size = 2'b10;
        @(negedge clock);
        chk("drop_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        chk("drop_idle_acc_gnt", {31'd0, acc_gnt}, 32'd0);
        next_cycle();
        @(negedge clock);
        chk("drop_then_acc_gnt", {31'd0, acc_gnt}, 32'd1);
        next_cycle();
        acc_req = 0;
        @(negedge clock);
        chk("drop_acc_rvalid", {31'd0, acc_rvalid}, 32'd1);
        chk("drop_acc_rdata", acc_rdata, 32'hDEAD_BEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the SoC data memory (`data_mem`, 0x1000_0000–0x1000_FFFF window). It shares that single-ported RAM between the CPU load/store unit and the ASCON accelerator's data mover. It grants one access per arbitration, drives the RAM's address, control and size/sign lines, and returns registered read data to the winning requester. It sits between the CPU MEM stage / ASCON engine and `data_mem`.

## Interface
Parameters:
- ADDR_W, 32, address width on all ports
- DATA_W, 32, data width on all ports
- LOCK_MAX, 8, max consecutive locked accelerator beats before forced release (1..255)

Ports:
- clock  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cpu_req / acc_req  in  1  access request; held with payload stable until gnt
- cpu_we / acc_we  in  1  1 = store, 0 = load
- cpu_addr / acc_addr  in  ADDR_W  byte address
- cpu_wdata / acc_wdata  in  DATA_W  store data
- cpu_size / acc_size  in  2  00 byte, 01 halfword, 10 word
- cpu_sext / acc_sext  in  1  1 = sign-extend load
- acc_lock  in  1  hold grant for the next accelerator beat
- cpu_gnt / acc_gnt  out  1  access performed this cycle
- cpu_rvalid / acc_rvalid  out  1  one-cycle pulse, load data valid
- cpu_rdata / acc_rdata  out  DATA_W  registered load data
- mem_address  out  ADDR_W  to data_mem address
- mem_write_data  out  DATA_W  to data_mem write_data
- mem_memwrite, mem_memread  out  1  to data_mem enables
- mem_byte_size  out  2  to data_mem byte_size
- mem_sign_ext  out  1  to data_mem sign_ext
- mem_read_data  in  DATA_W  combinational read data from data_mem

## Operation
- FSM states: IDLE, CPU_ACC, ACC_ACC.
- IDLE:
  - Single requester → go to its ACC state.
  - Both requesting → grant the requester not recorded in last_owner.
  - No request → stay IDLE.
- CPU_ACC / ACC_ACC:
  - Owner's payload drives the mem_* lines combinationally.
  - gnt = owner req.
  - mem_memwrite = req & we; mem_memread = req & ~we.
  - last_owner ← owner.
- Exit from an ACC state:
  - CPU_ACC → IDLE.
  - ACC_ACC → ACC_ACC if acc_lock=1 and lock_cnt < LOCK_MAX-1, incrementing lock_cnt; otherwise → IDLE with lock_cnt ← 0.
- Locked cycle with acc_req=0: no memory access, no gnt. The cycle still counts toward LOCK_MAX.
- In IDLE, or when the owner's req is low, every mem_* output is 0.
- Load capture: on the rising edge ending a granted load, mem_read_data goes into the owner's rdata, and the owner's rvalid is 1 for the next cycle. The non-owner's rdata holds.
- Request dropped during its ACC cycle (protocol violation): no access, no gnt, no rvalid; FSM still exits normally.

## Timing
- Reset values: state IDLE; last_owner = ACC (CPU wins first tie); lock_cnt 0; all gnt/rvalid 0; rdata 0; mem_* outputs 0.
- Latency:
  - req seen in IDLE at cycle N → gnt and memory access in N+1.
  - Store committed at the N+1→N+2 edge.
  - Load rvalid/rdata in N+2.
- Unlocked throughput: one access per 2 cycles. Locked accelerator burst: one beat per cycle.
- Simultaneous requests alternate strictly: CPU, ACC, CPU, … while both stay asserted.
- The CPU waits at most LOCK_MAX+1 cycles behind a locked burst.
- Asynchronous reset mid-access: mem_memwrite drops immediately. A store whose edge has not occurred is not performed. rvalid is cleared.

## Structure
- Shared package `dmem_arb_pkg`:
  - state encoding (IDLE/CPU_ACC/ACC_ACC)
  - owner encoding (OWN_CPU/OWN_ACC)
  - size codes SZ_BYTE/SZ_HALF/SZ_WORD
  - function rr_pick(cpu_req, acc_req, last_owner)
- Single module. No sub-module is warranted; the mux and capture logic are inline.

## Test plan
- CPU sw 0x1000_0010 ← 0xDEADBEEF, then lw same address → cpu_gnt in N+1, cpu_rvalid with 0xDEADBEEF in N+2.
- CPU lb (sext=1) and lbu from a byte holding 0x80 → 0xFFFFFF80, then 0x00000080.
- Both requests held continuously from reset → grants CPU, ACC, CPU, ACC on alternate access cycles.
- ACC with acc_lock=1 for 20 cycles, LOCK_MAX=8, CPU requesting → 8 consecutive acc_gnt, IDLE, then cpu_gnt.
- reset_n low during a CPU_ACC store cycle → mem_memwrite 0 at once, memory word unchanged, all outputs at reset values.
- Requester drops req in its ACC cycle → no gnt, no rvalid, FSM back to IDLE next cycle.
